regfile_wb_arbiter: RTL

Write-back arbiter for the 32×32 register file. It shares the file's single write port (`regwr`/`rw`/`busw`) between two write-back requesters: port 0 is the ALU and port 1 is the load unit. Arbitration is round-robin with a valid/ready handshake, and the write is issued from a registered output stage. An optional busy scoreboard tracks destination registers that have an outstanding write, for issue-stage hazard checks.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: default widths,
// register count and the write-request record {rd, data}.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant. The grant is combinational from the valids and
// the pointer; the pointer moves to the non-granted port after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Idle cycles leave the pointer alone so the favoured port keeps its turn.
  always_comb begin
    ptr_d = ptr_q;
    if (|grant_o) ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register-file write port between the ALU
// (port 0) and the load unit (port 1). Define REGFILE_WB_SCOREBOARD_EN to add
// the issue-side busy scoreboard (iss_valid/iss_rd/busy).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              regwr,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] busw
`ifdef REGFILE_WB_SCOREBOARD_EN
  ,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  output logic [(1<<ADDR_W)-1:0] busy
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t       req [2];
  req_t       sel;
  logic [1:0] valid, grant;
  logic       accept;

  assign req[0] = '{rd: req0_rd, data: req0_data};
  assign req[1] = '{rd: req1_rd, data: req1_data};
  assign valid  = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel        = grant[1] ? req[1] : req[0];

  // Output stage: x0 writes still consume the grant but never raise regwr.
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;

  always_comb begin
    regwr_d = 1'b0;
    rw_d    = rw_q;
    busw_d  = busw_q;
    if (accept) begin
      regwr_d = (sel.rd != '0);
      rw_d    = sel.rd;
      busw_d  = sel.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
    end
  end

  assign regwr = regwr_q;
  assign rw    = rw_q;
  assign busw  = busw_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [(1<<ADDR_W)-1:0] busy_q, busy_d;

  // Clear first, then set, so a same-edge re-issue keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (regwr_q) busy_d[rw_q] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
`endif

endmodule
